// File: rtl/fpu_div_pkg.sv
// Shared definitions for the radix-2 restoring significand divider:
// FSM state encoding, derived-width helpers and the divide-by-zero quotient pattern.
package fpu_div_pkg;

    typedef logic [1:0] div_state_t;

    localparam div_state_t ST_IDLE = 2'd0;
    localparam div_state_t ST_CALC = 2'd1;
    localparam div_state_t ST_DONE = 2'd2;

    // Wide enough for any supported significand; sliced to QW at the use site.
    localparam logic [127:0] DIV_DBZ_QUOT = '1;

    function automatic int div_qw(input int sw);
        return sw + 2;
    endfunction

    function automatic int div_cw(input int qw);
        return $clog2(qw);
    endfunction

endpackage

// File: rtl/sgf_div_radix2.sv
// Sequential radix-2 restoring significand divider, one quotient bit per clock.
// Optional macro DIV_EARLY_TERM_EN: finish as soon as the partial remainder reaches zero.
module sgf_div_radix2
    import fpu_div_pkg::*;
#(
    parameter  int SW = 24,
    localparam int QW = div_qw(SW)
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [SW-1:0] Data_A_i,
    input  logic [SW-1:0] Data_B_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [QW-1:0] sgf_quot_o,
    output logic          sticky_o,
    output logic          dbz_o
);

    localparam int            CW       = div_cw(QW);
    localparam logic [CW-1:0] CNT_INIT = CW'(QW - 1);

    div_state_t    r_state;
    div_state_t    w_state_next;
    logic [SW:0]   r_rem;
    logic [SW-1:0] r_div;
    logic [QW-1:0] r_quot;
    logic [CW-1:0] r_cnt;
    logic          r_pend;
    logic [SW-1:0] r_pend_a;
    logic [SW-1:0] r_pend_b;

    logic [SW:0]   w_rem_sub;
    logic [SW:0]   w_rem_next;
    logic          w_q_bit;
    logic [QW-1:0] w_quot_shift;
    logic          w_last;
    logic          w_early;
    logic          w_go;
    logic [SW-1:0] w_op_a;
    logic [SW-1:0] w_op_b;
    logic          w_load;
    logic [QW-1:0] w_load_quot;
    logic          w_load_sticky;
    logic          w_load_dbz;

    // Restoring step: trial subtract, keep the difference only when it is non-negative.
    assign w_q_bit      = (r_rem >= {1'b0, r_div});
    assign w_rem_sub    = r_rem - {1'b0, r_div};
    assign w_rem_next   = w_q_bit ? w_rem_sub : r_rem;
    assign w_quot_shift = {r_quot[QW-2:0], w_q_bit};
    assign w_last       = (r_cnt == '0);

`ifdef DIV_EARLY_TERM_EN
    assign w_early = (w_rem_next == '0) && !w_last;
`else
    assign w_early = 1'b0;
`endif

    // A start seen in DONE is parked and launched from IDLE with the parked operands.
    assign w_op_a = r_pend ? r_pend_a : Data_A_i;
    assign w_op_b = r_pend ? r_pend_b : Data_B_i;
    assign w_go   = (r_state == ST_IDLE) && (start_i || r_pend);

    assign busy_o = (r_state == ST_CALC);
    assign done_o = (r_state == ST_DONE);

    always_comb begin
        w_state_next  = r_state;
        w_load        = 1'b0;
        w_load_quot   = '0;
        w_load_sticky = 1'b0;
        w_load_dbz    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    if (w_op_b == '0) begin
                        w_state_next = ST_DONE;
                        w_load       = 1'b1;
                        w_load_quot  = DIV_DBZ_QUOT[QW-1:0];
                        w_load_dbz   = 1'b1;
                    end else begin
                        w_state_next = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (w_last || w_early) begin
                    w_state_next  = ST_DONE;
                    w_load        = 1'b1;
                    // Remaining bits are all zero after an exact early finish.
                    w_load_quot   = w_early ? (w_quot_shift << r_cnt) : w_quot_shift;
                    w_load_sticky = (w_rem_next != '0);
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_rem    <= '0;
            r_div    <= '0;
            r_quot   <= '0;
            r_cnt    <= '0;
            r_pend   <= 1'b0;
            r_pend_a <= '0;
            r_pend_b <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_pend <= 1'b0;
                        if (w_op_b != '0) begin
                            r_div  <= w_op_b;
                            r_rem  <= {1'b0, w_op_a};
                            r_cnt  <= CNT_INIT;
                            r_quot <= '0;
                        end
                    end
                end
                ST_CALC: begin
                    r_quot <= w_quot_shift;
                    if (!w_last) begin
                        r_rem <= {w_rem_next[SW-1:0], 1'b0};
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_DONE: begin
                    if (start_i) begin
                        r_pend   <= 1'b1;
                        r_pend_a <= Data_A_i;
                        r_pend_b <= Data_B_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result register: loads on the transition into DONE, otherwise holds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sgf_quot_o <= '0;
            sticky_o   <= 1'b0;
            dbz_o      <= 1'b0;
        end else if (w_load) begin
            sgf_quot_o <= w_load_quot;
            sticky_o   <= w_load_sticky;
            dbz_o      <= w_load_dbz;
        end else if (w_go) begin
            dbz_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sgf_div_radix2.sv
// Self-checking bench for sgf_div_radix2: arithmetic reference model plus directed vectors.
module tb_sgf_div_radix2;

    localparam int SW = 24;
    localparam int QW = SW + 2;

`ifdef DIV_EARLY_TERM_EN
    localparam int LAT_EQ = 1;
    localparam int LAT_C8 = 2;
`else
    localparam int LAT_EQ = QW;
    localparam int LAT_C8 = QW;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic [SW-1:0] a = '0;
    logic [SW-1:0] b = '0;
    logic          busy_o;
    logic          done_o;
    logic [QW-1:0] sgf_quot_o;
    logic          sticky_o;
    logic          dbz_o;

    always #5 clk = ~clk;

    sgf_div_radix2 #(.SW(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .Data_A_i   (a),
        .Data_B_i   (b),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .sgf_quot_o (sgf_quot_o),
        .sticky_o   (sticky_o),
        .dbz_o      (dbz_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: quotient and remainder by plain integer division; early finish is the
    // first step whose partial remainder A*2^(i-1) mod B is zero.
    function automatic void model(input logic [SW-1:0] ma, input logic [SW-1:0] mb,
                                  output logic [QW-1:0] mq, output bit ms, output bit md,
                                  output int ml);
        logic [63:0] num;
        logic [63:0] den;
        if (mb == '0) begin
            mq = '1;
            ms = 1'b0;
            md = 1'b1;
            ml = 0;
            return;
        end
        num = 64'(ma) << (SW + 1);
        den = 64'(mb);
        mq  = QW'(num / den);
        ms  = (num % den) != 0;
        md  = 1'b0;
        ml  = QW;
`ifdef DIV_EARLY_TERM_EN
        for (int i = 1; i < QW; i++) begin
            if (((64'(ma) << (i - 1)) % den) == 0) begin
                ml = i;
                break;
            end
        end
`endif
    endfunction

    int            cyc = 0;
    bit            pend = 1'b0;
    int            t0 = 0;
    int            lat = 0;
    logic [QW-1:0] e_q = '0;
    bit            e_s = 1'b0;
    bit            e_d = 1'b0;
    logic [QW-1:0] h_q = '0;
    bit            h_s = 1'b0;
    bit            h_d = 1'b0;
    bit            e_done = 1'b0;
    bit            e_busy = 1'b0;

    always @(posedge clk) begin
        cyc++;
        e_done = 1'b0;
        if (!rst) begin
            pend = 1'b0;
            h_q  = '0;
            h_s  = 1'b0;
            h_d  = 1'b0;
        end else if (pend) begin
            if (cyc == t0 + lat) begin
                e_done = 1'b1;
                pend   = 1'b0;
                h_q    = e_q;
                h_s    = e_s;
                h_d    = e_d;
            end
        end else if (start_i) begin
            model(a, b, e_q, e_s, e_d, lat);
            t0  = cyc;
            h_d = 1'b0;
            if (lat == 0) begin
                e_done = 1'b1;
                h_q    = e_q;
                h_s    = e_s;
                h_d    = e_d;
            end else begin
                pend = 1'b1;
            end
        end
        e_busy = pend;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("done_o", 64'(done_o), 64'(e_done));
            chk("busy_o", 64'(busy_o), 64'(e_busy));
            chk("dbz_o", 64'(dbz_o), 64'(h_d));
            if (!e_busy) begin
                chk("sgf_quot_o", 64'(sgf_quot_o), 64'(h_q));
                chk("sticky_o", 64'(sticky_o), 64'(h_s));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string nm, input int cs, input int llat, input bit lit);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #1;
            if (done_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, " done_seen"}, 64'(ok), 64'd1);
        if (ok && lit) chk({nm, " latency"}, 64'(cyc - cs), 64'(llat));
    endtask

    task automatic run_op(input string nm, input logic [SW-1:0] va, input logic [SW-1:0] vb,
                          input bit lit, input logic [QW-1:0] lq, input bit ls, input bit ld,
                          input int llat);
        int cs;
        a = va;
        b = vb;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cs = cyc;
        if (vb != '0) chk({nm, " dbz_cleared"}, 64'(dbz_o), 64'd0);
        wait_done(nm, cs, llat, lit);
        if (lit) begin
            chk({nm, " quot"}, 64'(sgf_quot_o), 64'(lq));
            chk({nm, " sticky"}, 64'(sticky_o), 64'(ls));
            chk({nm, " dbz"}, 64'(dbz_o), 64'(ld));
        end
        tick();
        $display("op %s A=0x%06h B=0x%06h -> quot=0x%07h sticky=%0b dbz=%0b",
                 nm, va, vb, sgf_quot_o, sticky_o, dbz_o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs;
        rst = 1'b0;
        repeat (3) tick();
        chk("reset quot", 64'(sgf_quot_o), 64'd0);
        chk("reset busy", 64'(busy_o), 64'd0);
        rst = 1'b1;
        tick();

        run_op("a_eq_b", 24'h800000, 24'h800000, 1'b1, 26'h2000000, 1'b0, 1'b0, LAT_EQ);
        run_op("c8_div_8", 24'hC00000, 24'h800000, 1'b1, 26'h3000000, 1'b0, 1'b0, LAT_C8);
        run_op("8_div_c", 24'h800000, 24'hC00000, 1'b1, 26'h1555555, 1'b1, 1'b0, QW);
        run_op("ff_eq_ff", 24'hFFFFFF, 24'hFFFFFF, 1'b1, 26'h2000000, 1'b0, 1'b0, LAT_EQ);
        run_op("dbz", 24'h900000, 24'h000000, 1'b1, 26'h3FFFFFF, 1'b0, 1'b1, 0);
        run_op("after_dbz", 24'hABCDEF, 24'h9ABCDE, 1'b0, '0, 1'b0, 1'b0, 0);
        run_op("8_div_ff", 24'h800000, 24'hFFFFFF, 1'b0, '0, 1'b0, 1'b0, 0);
        run_op("ff_div_8", 24'hFFFFFF, 24'h800000, 1'b0, '0, 1'b0, 1'b0, 0);
        run_op("ff_div_801", 24'hFFFFFF, 24'h800001, 1'b0, '0, 1'b0, 1'b0, 0);

        // Second start during CALC must be ignored.
        a = 24'h800000;
        b = 24'hC00000;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cs = cyc;
        repeat (5) tick();
        a = 24'hC00000;
        b = 24'h800000;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        a = '0;
        b = '0;
        wait_done("ignore_start", cs, QW, 1'b1);
        chk("ignore_start quot", 64'(sgf_quot_o), 64'h1555555);
        chk("ignore_start sticky", 64'(sticky_o), 64'd1);
        repeat (30) tick();
        $display("op ignore_start -> quot=0x%07h sticky=%0b", sgf_quot_o, sticky_o);

        // Reset at iteration 10 aborts without done_o.
        a = 24'h800000;
        b = 24'hC00000;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (9) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort busy", 64'(busy_o), 64'd0);
        chk("abort quot", 64'(sgf_quot_o), 64'd0);
        chk("abort sticky", 64'(sticky_o), 64'd0);
        repeat (30) tick();
        $display("op reset_abort -> busy=%0b done=%0b quot=0x%07h", busy_o, done_o, sgf_quot_o);
        run_op("post_reset", 24'hC00000, 24'h800000, 1'b1, 26'h3000000, 1'b0, 1'b0, LAT_C8);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
